// File: rtl/keycode_queue.sv
// -----------------------------------------------------------------------------
// keycode_queue
//
// Purpose:
//   Turns the PS/2 set-2 byte stream into complete key events and buffers
//   them in a show-ahead FIFO. The processor can then take events at its own
//   pace without losing any. The decoder handles these sequences:
//     - E0 extended prefix
//     - F0 break prefix
//     - E1 pause sequence
//   The decoder also drops controller response bytes. An optional filter
//   suppresses typematic repeats of the key that is currently held down.
//
// Parameters:
//   DEPTH          FIFO entries, power of 2, >= 2
//   FILTER_REPEAT  1: drop repeated make events of the held key
//   PAUSE_EN       1: the 8-byte E1 sequence becomes one {ext=1,make=1,E1}
//                  event; 0: the sequence is swallowed
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        synchronous active-low reset
//   ps2_key_en     one-cycle strobe, ps2_key_data valid
//   ps2_key_data   received PS/2 byte
//   rd_ready       consumer takes the head entry this cycle
//   clr_ovf        clears the sticky overflow flag
//   keycode        head entry scan code (holds last value when empty)
//   ext            head entry had the E0 prefix
//   make           head entry is a press (1) or a release (0)
//   keycode_valid  FIFO non-empty
//   count          occupied entries
//   overflow       sticky: an event was dropped because the FIFO was full
//
// Decoder states:
//   state     | meaning
//   ----------+----------------------------------------------------
//   S_IDLE    | waiting for the first byte of a key event
//   S_EXT     | E0 seen, next byte is an extended code or F0
//   S_BRK     | F0 seen, next byte is the released code
//   S_EXT_BRK | E0 F0 seen, next byte is the released extended code
//   S_PAUSE   | inside the E1 pause sequence, skipping remaining bytes
// -----------------------------------------------------------------------------
module keycode_queue #(
    parameter int DEPTH         = 8,
    parameter bit FILTER_REPEAT = 1'b1,
    parameter bit PAUSE_EN      = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       ps2_key_en,
    input  logic [7:0]                 ps2_key_data,
    input  logic                       rd_ready,
    input  logic                       clr_ovf,
    output logic [7:0]                 keycode,
    output logic                       ext,
    output logic                       make,
    output logic                       keycode_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_PAUSE
    } state_t;

    // ------------------------------------------------------------------
    // Decoder FSM
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_pause_cnt;
    logic [2:0] w_pause_cnt_nxt;

    logic       w_ev_valid;
    logic       w_ev_ext;
    logic       w_ev_make;
    logic [7:0] w_ev_code;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_pause_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pause_cnt <= w_pause_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pause_cnt_nxt = r_pause_cnt;
        w_ev_valid      = 1'b0;
        w_ev_ext        = 1'b0;
        w_ev_make       = 1'b0;
        w_ev_code       = ps2_key_data;

        if (ps2_key_en) begin
            case (r_state)
                S_IDLE: begin
                    case (ps2_key_data)
                        8'hE0: w_state_nxt = S_EXT;
                        8'hF0: w_state_nxt = S_BRK;
                        8'hE1: begin
                            w_state_nxt     = S_PAUSE;
                            w_pause_cnt_nxt = 3'd7;
                        end
                        // Controller responses (ACK, BAT result, echo, ...)
                        8'h00, 8'hAA, 8'hEE, 8'hFA,
                        8'hFC, 8'hFE, 8'hFF: begin
                            w_state_nxt = S_IDLE;
                        end
                        default: begin
                            w_ev_valid = 1'b1;
                            w_ev_make  = 1'b1;
                        end
                    endcase
                end

                S_EXT: begin
                    if (ps2_key_data == 8'hF0) begin
                        w_state_nxt = S_EXT_BRK;
                    end else if (ps2_key_data != 8'hE0) begin
                        w_ev_valid  = 1'b1;
                        w_ev_ext    = 1'b1;
                        w_ev_make   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end

                S_BRK: begin
                    w_ev_valid  = 1'b1;
                    w_state_nxt = S_IDLE;
                end

                S_EXT_BRK: begin
                    w_ev_valid  = 1'b1;
                    w_ev_ext    = 1'b1;
                    w_state_nxt = S_IDLE;
                end

                S_PAUSE: begin
                    w_pause_cnt_nxt = r_pause_cnt - 3'd1;
                    // A count of 1 here means this byte takes it to 0 and
                    // ends the sequence. A count of 0 cannot occur, but it
                    // is also treated as the end so the FSM cannot stall.
                    if (r_pause_cnt <= 3'd1) begin
                        w_pause_cnt_nxt = '0;
                        w_state_nxt     = S_IDLE;
                        w_ev_valid      = PAUSE_EN;
                        w_ev_ext        = 1'b1;
                        w_ev_make       = 1'b1;
                        w_ev_code       = 8'hE1;
                    end
                end

                default: begin
                    w_state_nxt     = S_IDLE;
                    w_pause_cnt_nxt = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Typematic repeat filter
    // The held key is updated whenever a make gets through the filter,
    // even if the FIFO then has no room for it. The pause event is an
    // ordinary make as far as the filter is concerned.
    // ------------------------------------------------------------------
    logic       r_held_valid;
    logic [8:0] r_held;
    logic [8:0] w_ev_key;
    logic       w_held_hit;
    logic       w_drop;

    assign w_ev_key   = {w_ev_ext, w_ev_code};
    assign w_held_hit = r_held_valid && (r_held == w_ev_key);
    assign w_drop     = FILTER_REPEAT && w_ev_valid && w_ev_make && w_held_hit;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_held_valid <= 1'b0;
            r_held       <= '0;
        end else if (FILTER_REPEAT && w_ev_valid) begin
            if (w_ev_make) begin
                if (!w_held_hit) begin
                    r_held_valid <= 1'b1;
                    r_held       <= w_ev_key;
                end
            end else if (w_held_hit) begin
                r_held_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // The head is kept in output registers. Each cycle these registers are
    // loaded with the entry that will be at the head after this cycle's
    // pop and push. This gives registered outputs that hold their value
    // once the FIFO is empty.
    // ------------------------------------------------------------------
    logic [9:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [7:0]    r_key;
    logic          r_ext;
    logic          r_make;

    logic          w_valid;
    logic          w_full;
    logic          w_push_req;
    logic          w_push;
    logic          w_pop;
    logic          w_ovf_set;
    logic [9:0]    w_push_data;
    logic [AW-1:0] w_rd_nxt;
    logic [CW-1:0] w_remain;
    logic [9:0]    w_head_nxt;

    assign w_valid     = (r_count != '0);
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_push_req  = w_ev_valid && !w_drop;
    assign w_pop       = w_valid && rd_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_ovf_set   = w_push_req && w_full && !w_pop;
    assign w_push_data = {w_ev_ext, w_ev_make, w_ev_code};
    assign w_rd_nxt    = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
    // Entries left after the pop and before the push.
    assign w_remain    = r_count - CW'(w_pop);

    always_comb begin
        w_head_nxt = {r_ext, r_make, r_key};
        if (w_remain != '0) begin
            w_head_nxt = r_mem[w_rd_nxt];
        end else if (w_push) begin
            w_head_nxt = w_push_data;
        end
    end

    // Storage needs no reset; the pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (reset_n && w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_key    <= '0;
            r_ext    <= 1'b0;
            r_make   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_nxt;
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
            r_ext    <= w_head_nxt[9];
            r_make   <= w_head_nxt[8];
            r_key    <= w_head_nxt[7:0];
            // When a set and a clear arrive in the same cycle, the set wins.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign keycode       = r_key;
    assign ext           = r_ext;
    assign make          = r_make;
    assign keycode_valid = w_valid;
    assign count         = r_count;
    assign overflow      = r_ovf;

endmodule

// File: tb/tb_keycode_queue.sv
// -----------------------------------------------------------------------------
// tb_keycode_queue
//
// Drives three instances of keycode_queue from the same inputs:
//   d0  default parameters
//   d1  FILTER_REPEAT = 0
//   d2  PAUSE_EN = 0
// The bench applies a vector table, then hand-written corner sequences, then
// random traffic. The random traffic is compared against a queue-based
// reference model.
// -----------------------------------------------------------------------------
module tb_keycode_queue;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          ps2_key_en;
    logic [7:0]    ps2_key_data;
    logic          rd_ready;
    logic          clr_ovf;

    logic [7:0]    d0_keycode, d1_keycode, d2_keycode;
    logic          d0_ext, d1_ext, d2_ext;
    logic          d0_make, d1_make, d2_make;
    logic          d0_valid, d1_valid, d2_valid;
    logic [CW-1:0] d0_count, d1_count, d2_count;
    logic          d0_ovf, d1_ovf, d2_ovf;

    keycode_queue #(.DEPTH(DEPTH), .FILTER_REPEAT(1'b1), .PAUSE_EN(1'b1)) d0 (
        .clk(clk), .reset_n(reset_n), .ps2_key_en(ps2_key_en),
        .ps2_key_data(ps2_key_data), .rd_ready(rd_ready), .clr_ovf(clr_ovf),
        .keycode(d0_keycode), .ext(d0_ext), .make(d0_make),
        .keycode_valid(d0_valid), .count(d0_count), .overflow(d0_ovf));

    keycode_queue #(.DEPTH(DEPTH), .FILTER_REPEAT(1'b0), .PAUSE_EN(1'b1)) d1 (
        .clk(clk), .reset_n(reset_n), .ps2_key_en(ps2_key_en),
        .ps2_key_data(ps2_key_data), .rd_ready(rd_ready), .clr_ovf(clr_ovf),
        .keycode(d1_keycode), .ext(d1_ext), .make(d1_make),
        .keycode_valid(d1_valid), .count(d1_count), .overflow(d1_ovf));

    keycode_queue #(.DEPTH(DEPTH), .FILTER_REPEAT(1'b1), .PAUSE_EN(1'b0)) d2 (
        .clk(clk), .reset_n(reset_n), .ps2_key_en(ps2_key_en),
        .ps2_key_data(ps2_key_data), .rd_ready(rd_ready), .clr_ovf(clr_ovf),
        .keycode(d2_keycode), .ext(d2_ext), .make(d2_make),
        .keycode_valid(d2_valid), .count(d2_count), .overflow(d2_ovf));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock cycle: inputs are held across the rising edge, then sampled
    // 1 time unit after it.
    task automatic cyc(input logic en, input logic [7:0] d, input logic rdy, input logic clr);
        ps2_key_en   = en;
        ps2_key_data = d;
        rd_ready     = rdy;
        clr_ovf      = clr;
        @(posedge clk);
        #1;
        ps2_key_en   = 1'b0;
        ps2_key_data = 8'h00;
        rd_ready     = 1'b0;
        clr_ovf      = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    function automatic logic [9:0] head0();
        return {d0_ext, d0_make, d0_keycode};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic          en;
        logic [7:0]    data;
        logic          rdy;
        logic          clr;
        logic          e_valid;
        logic [CW-1:0] e_count;
        logic [7:0]    e_key;
        logic          e_ext;
        logic          e_make;
        logic          e_ovf;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic [7:0] data, input logic rdy,
                                input logic clr, input logic ev, input int ec,
                                input logic [7:0] ek, input logic ee, input logic em,
                                input logic eo);
        vec_t v;
        v.en = en; v.data = data; v.rdy = rdy; v.clr = clr;
        v.e_valid = ev; v.e_count = CW'(ec); v.e_key = ek;
        v.e_ext = ee; v.e_make = em; v.e_ovf = eo;
        return v;
    endfunction

    vec_t vecs[$];

    // ---------------- reference model ----------------
    localparam bit M_PAUSE_EN = 1'b1;
    logic [7:0] m_seq[$];
    logic [9:0] m_q[$];
    int         m_held;
    logic       m_ovf;
    logic [9:0] m_head;

    // Accumulates bytes until they form one complete sequence, then yields
    // the event it describes: {ext, make, code}.
    task automatic model_byte(input logic [7:0] b, output bit ev, output logic [9:0] e);
        ev = 1'b0;
        e  = '0;
        m_seq.push_back(b);
        if (m_seq[0] == 8'hE1) begin
            if (m_seq.size() == 8) begin
                ev = M_PAUSE_EN;
                e  = {2'b11, 8'hE1};
                m_seq.delete();
            end
        end else if (m_seq[0] == 8'hE0) begin
            if (m_seq.size() == 2 && b == 8'hE0) begin
                void'(m_seq.pop_back());
            end else if (m_seq.size() == 2 && b == 8'hF0) begin
                ev = 1'b0;
            end else if (m_seq.size() >= 2) begin
                ev = 1'b1;
                e  = {1'b1, (m_seq.size() == 2), b};
                m_seq.delete();
            end
        end else if (m_seq[0] == 8'hF0) begin
            if (m_seq.size() == 2) begin
                ev = 1'b1;
                e  = {2'b00, b};
                m_seq.delete();
            end
        end else begin
            if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF})) begin
                ev = 1'b1;
                e  = {2'b01, b};
            end
            m_seq.delete();
        end
    endtask

    task automatic model_cycle(input logic en, input logic [7:0] b, input logic rdy, input logic clr);
        bit         ev;
        logic [9:0] e;
        int         key;
        bit         set;
        set = 1'b0;
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        if (en) begin
            model_byte(b, ev, e);
            if (ev) begin
                key = int'({e[9], e[7:0]});
                if (e[8]) begin
                    if (key == m_held) ev = 1'b0;
                    else m_held = key;
                end else if (key == m_held) begin
                    m_held = -1;
                end
            end
            if (ev) begin
                if (m_q.size() < DEPTH) m_q.push_back(e);
                else set = 1'b1;
            end
        end
        if (set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (m_q.size() > 0) m_head = m_q[0];
    endtask

    // ---------------- test ----------------
    initial begin
        logic [7:0] seq_rep[6];
        logic [9:0] exp_rep[3];
        logic [7:0] seq_pause[12];
        logic [7:0] picks[12];
        logic [9:0] exp_drain[8];

        seq_rep   = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
        exp_rep   = '{10'h11C, 10'h01C, 10'h11C};
        seq_pause = '{8'hAA, 8'hFA, 8'hE1, 8'h14, 8'h77, 8'hE1,
                      8'hF0, 8'h14, 8'hF0, 8'h77, 8'hFA, 8'hAA};
        picks     = '{8'h1C, 8'h1B, 8'h23, 8'h75, 8'h14, 8'h77,
                      8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h00};
        exp_drain = '{10'h116, 10'h117, 10'h118, 10'h119,
                      10'h11A, 10'h11B, 10'h11C, 10'h121};

        //              en    data   rdy clr  val cnt key    ext make ovf
        vecs.push_back(mk(1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 1, 8'h1C, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, 1, 8'h1C, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 2, 8'h1C, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1, 8'h1C, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h1C, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h1C, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 8'hE0, 1'b0, 1'b0, 1'b0, 0, 8'h1C, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 8'h75, 1'b0, 1'b0, 1'b1, 1, 8'h75, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 8'hE0, 1'b0, 1'b0, 1'b1, 1, 8'h75, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, 1, 8'h75, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 8'h75, 1'b0, 1'b0, 1'b1, 2, 8'h75, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 8'hF0, 1'b1, 1'b0, 1'b1, 1, 8'h75, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 8'h75, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 8'h1C, 1'b1, 1'b0, 1'b1, 1, 8'h1C, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h1C, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 8'h2A, 1'b1, 1'b0, 1'b1, 1, 8'h2A, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h2A, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 0, 8'h2A, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 8'hFA, 1'b0, 1'b0, 1'b0, 0, 8'h2A, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 0, 8'h2A, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 8'h2A, 1'b0, 1'b1, 1'b0));

        reset_n = 1'b0; ps2_key_en = 1'b0; ps2_key_data = 8'h00;
        rd_ready = 1'b0; clr_ovf = 1'b0;
        do_reset();

        chk("rst valid", d0_valid, 1'b0);
        chk("rst count", d0_count, '0);
        chk("rst head", head0(), '0);
        chk("rst ovf", d0_ovf, 1'b0);

        foreach (vecs[i]) begin
            cyc(vecs[i].en, vecs[i].data, vecs[i].rdy, vecs[i].clr);
            chk($sformatf("vec%0d valid", i), d0_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d count", i), d0_count, vecs[i].e_count);
            chk($sformatf("vec%0d key", i), d0_keycode, vecs[i].e_key);
            chk($sformatf("vec%0d ext", i), d0_ext, vecs[i].e_ext);
            chk($sformatf("vec%0d make", i), d0_make, vecs[i].e_make);
            chk($sformatf("vec%0d ovf", i), d0_ovf, vecs[i].e_ovf);
        end

        // Repeat filter: 3 entries with filtering, 5 without.
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, seq_rep[i], 1'b0, 1'b0);
        chk("rep count filt", d0_count, 3);
        chk("rep count nofilt", d1_count, 5);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rep head%0d", k), head0(), exp_rep[k]);
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("rep drained", d0_valid, 1'b0);

        // Pause sequence surrounded by controller responses.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, seq_pause[i], 1'b0, 1'b0);
            chk($sformatf("pause cnt b%0d", i), d0_count, (i >= 9) ? 1 : 0);
            chk($sformatf("nopause cnt b%0d", i), d2_count, 0);
        end
        chk("pause head", head0(), 10'h3E1);
        chk("pause nofilt cnt", d1_count, 1);
        chk("nopause valid", d2_valid, 1'b0);

        // Overflow and full-FIFO behaviour.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 8'h15 + 8'(i), 1'b0, 1'b0);
            chk($sformatf("fill cnt%0d", i), d0_count, (i < 8) ? i + 1 : 8);
            chk($sformatf("fill ovf%0d", i), d0_ovf, (i == 8) ? 1 : 0);
        end
        chk("full head", head0(), 10'h115);
        cyc(1'b1, 8'h21, 1'b1, 1'b0);
        chk("full pushpop cnt", d0_count, 8);
        chk("full pushpop head", head0(), 10'h116);
        chk("full pushpop ovf", d0_ovf, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr ovf", d0_ovf, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b1);
        chk("set wins ovf", d0_ovf, 1'b1);
        chk("set wins cnt", d0_count, 8);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr ovf2", d0_ovf, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d", k), head0(), exp_drain[k]);
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain empty", d0_valid, 1'b0);

        // Reset during an E0 prefix abandons it.
        do_reset();
        cyc(1'b1, 8'h1C, 1'b0, 1'b0);
        cyc(1'b1, 8'hE0, 1'b0, 1'b0);
        chk("pre-rst count", d0_count, 1);
        reset_n = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("inrst valid", d0_valid, 1'b0);
        chk("inrst count", d0_count, '0);
        chk("inrst key", d0_keycode, '0);
        chk("inrst ext", d0_ext, 1'b0);
        chk("inrst make", d0_make, 1'b0);
        chk("inrst ovf", d0_ovf, 1'b0);
        reset_n = 1'b1;
        cyc(1'b1, 8'h75, 1'b0, 1'b0);
        chk("postrst count", d0_count, 1);
        chk("postrst head", head0(), 10'h175);

        // Random traffic against the reference model.
        do_reset();
        m_seq.delete();
        m_q.delete();
        m_held = -1;
        m_ovf  = 1'b0;
        m_head = '0;
        for (int c = 0; c < 3000; c++) begin
            logic       en, rdy, clr;
            logic [7:0] b;
            en  = ($urandom_range(0, 9) < 6);
            b   = ($urandom_range(0, 4) == 0) ? 8'($urandom) : picks[$urandom_range(0, 11)];
            rdy = ($urandom_range(0, 9) < 4);
            clr = ($urandom_range(0, 19) == 0);
            if (m_q.size() == DEPTH) rdy = 1'b1;
            model_cycle(en, b, rdy, clr);
            cyc(en, b, rdy, clr);
            chk("rnd count", d0_count, m_q.size());
            chk("rnd valid", d0_valid, (m_q.size() > 0) ? 1 : 0);
            chk("rnd head", head0(), m_head);
            chk("rnd ovf", d0_ovf, m_ovf);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/keycode_queue.md
Name: keycode_queue

Overview:
- Parametrised successor to the single-register keycode recognizer.
- Decodes the PS/2 set-2 byte stream (E0 extension, F0 break, E1 pause) into complete key events and buffers them in a show-ahead FIFO with a ready/valid pop interface.
- Sits between the PS/2 byte receiver and the processor, so no key event is lost while the processor is busy plotting.
- Adds typematic-repeat filtering, discarding of controller response bytes, and sticky overflow reporting.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- FILTER_REPEAT, 1, when 1 drop repeated make events of the currently held key.
- PAUSE_EN, 1, when 1 collapse the 8-byte E1 pause sequence into one event; when 0 discard it.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- ps2_key_en  in  1  one-cycle strobe: ps2_key_data valid.
- ps2_key_data  in  8  received PS/2 byte.
- rd_ready  in  1  consumer accepts head entry this cycle.
- clr_ovf  in  1  clears the sticky overflow flag.
- keycode  out  8  head entry scan code.
- ext  out  1  head entry had E0 prefix.
- make  out  1  head entry is press (1) or release (0).
- keycode_valid  out  1  FIFO non-empty.
- count  out  $clog2(DEPTH+1)  occupied entries.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Reset: all outputs 0 (keycode, ext, make, keycode_valid, count, overflow); FSM to IDLE; FIFO pointers 0; held-key register invalid; pause counter 0.
- Reset while a prefix or pause sequence is in progress abandons it. No partial event is pushed.
- Bytes are processed only in cycles with ps2_key_en=1. All other cycles leave the FSM unchanged.
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE, loading the skip counter with 7.
  - 00, AA, EE, FA, FC, FE, FF are discarded; stay in IDLE.
  - Any other byte b pushes {ext=0, make=1, b}.
- EXT: F0 -> EXT_BRK; E0 stays in EXT; any other b pushes {1,1,b} -> IDLE.
- BRK: any b pushes {0,0,b} -> IDLE.
- EXT_BRK: any b pushes {1,0,b} -> IDLE.
- PAUSE:
  - Decrement the counter per byte.
  - When the counter reaches 0, return to IDLE.
  - If PAUSE_EN=1, push {1,1,8'hE1} on that final byte.
- Repeat filter (FILTER_REPEAT=1):
  - Holds {ext,code} of the last accepted make.
  - A make matching the held value is dropped and neither pushed nor counted as overflow.
  - A break matching the held value clears it.
  - A non-matching make replaces it.
  - Break events are never filtered.
- FIFO:
  - Show-ahead: keycode, ext and make reflect the head entry whenever keycode_valid=1, and hold their last value when empty.
  - Pop when keycode_valid && rd_ready.
  - Push latency: byte strobe at cycle t makes the entry visible and count updated at t+1. If the FIFO was empty, keycode_valid rises at t+1.
  - Full with push and no pop: the new event is dropped, overflow is set at t+1, and contents are unchanged.
  - Full with push and pop in the same cycle: both occur, count stays DEPTH, no overflow.
  - Empty with push and pop in the same cycle: the pop is ignored because valid=0, and the push proceeds.
  - Pointers wrap modulo DEPTH.
- overflow stays at 1 until clr_ovf=1. If set and clear coincide, set wins.

Test Plan:
- Reset, then bytes 1C, F0, 1C with rd_ready=0 -> count=2; head {ext0, make1, 1C}; after one pop, head {0,0,1C}; keycode_valid drops after the second pop.
- E0 75, E0 F0 75 -> entries {1,1,75} then {1,0,75}. A strobe of F0 at cycle t followed by nothing leaves count unchanged.
- FILTER_REPEAT=1: 1C, 1C, 1C, F0 1C, 1C -> exactly 3 entries: make, break, make. With FILTER_REPEAT=0 the same stimulus gives 5 entries.
- E1 14 77 E1 F0 14 F0 77 with PAUSE_EN=1 -> single entry {1,1,E1}. With PAUSE_EN=0 -> no entries. Bytes AA and FA interleaved in IDLE -> no entries.
- DEPTH=8: push 9 makes of distinct codes with rd_ready=0 -> count=8, overflow=1, head is the first code. Push plus pop at full -> count stays 8, order preserved. clr_ovf -> overflow=0.
- Assert reset_n=0 for one cycle after an E0 strobe, then send 75 -> entry {0,1,75}; all outputs are 0 during the reset cycle.
